// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and packed-matrix layout for the matrix-multiply share arbiter
package mm_pkg;

    localparam int MM_ELEM_W = 8;
    localparam int MM_MAT_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mm_state_e;

    // LSB of element [i][j] in a packed 2x2 matrix; [0][0] is the top byte.
    function automatic int mm_elem_lsb(input int i, input int j);
        return MM_MAT_W - MM_ELEM_W * (2 * i + j + 1);
    endfunction

endpackage

// File: rtl/mm_share_arbiter_if.sv
// rtl/mm_share_arbiter_if.sv - requester, engine and status signals of the share arbiter
interface mm_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int MW    = 32
);
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*MW-1:0] req_a;
    logic [N_REQ*MW-1:0] req_b;
    logic [N_REQ-1:0]    resp_valid;
    logic [N_REQ-1:0]    resp_ready;
    logic [MW-1:0]       resp_res;
    logic                eng_in_valid;
    logic                eng_in_ready;
    logic [MW-1:0]       eng_a;
    logic [MW-1:0]       eng_b;
    logic                eng_out_valid;
    logic                eng_out_ready;
    logic [MW-1:0]       eng_res;
    logic [OW-1:0]       owner;
    logic                busy;
    logic [15:0]         done_count;

    // The arbiter is the slave; requesters and engine together form the master side.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready, eng_in_ready, eng_out_valid, eng_res,
        output req_ready, resp_valid, resp_res, eng_in_valid, eng_a, eng_b, eng_out_ready,
        output owner, busy, done_count
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready, eng_in_ready, eng_out_valid, eng_res,
        input  req_ready, resp_valid, resp_res, eng_in_valid, eng_a, eng_b, eng_out_ready,
        input  owner, busy, done_count
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or above ptr, wrapping
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int OW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [OW-1:0]    idx,
    output logic             found
);

    logic [OW:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (OW+1)'(k);
            if (cand >= (OW+1)'(N_REQ)) begin
                cand = cand - (OW+1)'(N_REQ);
            end
            if (!found && req[cand[OW-1:0]]) begin
                found                 = 1'b1;
                grant[cand[OW-1:0]]   = 1'b1;
                idx                   = cand[OW-1:0];
            end
        end
    end

endmodule

// File: rtl/mm_share_arbiter.sv
// rtl/mm_share_arbiter.sv - shares one 2x2 matrix-multiply engine among N_REQ requesters, round robin
module mm_share_arbiter
    import mm_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int MW    = MM_MAT_W
) (
    input  logic              clock,
    input  logic              reset,
    mm_share_arbiter_if.slave bus
);

    localparam int OW = $clog2(N_REQ);

    mm_state_e        state_q, state_d;
    logic [MW-1:0]    op_a_q, op_b_q, res_q;
    logic [OW-1:0]    owner_q, rr_ptr_q;
    logic [15:0]      done_count_q;

    logic [N_REQ-1:0] pick_grant;
    logic [OW-1:0]    pick_idx;
    logic             pick_found;
    logic [OW:0]      pick_inc;
    logic [OW-1:0]    rr_next;

    logic             accept;
    logic             eng_out_fire;
    logic             resp_fire;

    rr_pick #(.N_REQ(N_REQ), .OW(OW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Pointer moves one past the winner so it gets lowest priority next round.
    assign pick_inc = {1'b0, pick_idx} + (OW+1)'(1);
    assign rr_next  = (pick_inc == (OW+1)'(N_REQ)) ? '0 : pick_inc[OW-1:0];

    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        eng_out_fire      = 1'b0;
        resp_fire         = 1'b0;
        bus.req_ready     = '0;
        bus.resp_valid    = '0;
        bus.eng_in_valid  = 1'b0;
        bus.eng_out_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = pick_grant;
                if (pick_found) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.eng_in_valid = 1'b1;
                if (bus.eng_in_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                bus.eng_out_ready = 1'b1;
                if (bus.eng_out_valid) begin
                    eng_out_fire = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                bus.resp_valid[owner_q] = 1'b1;
                if (bus.resp_ready[owner_q]) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_q        <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            done_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q   <= bus.req_a[int'(pick_idx)*MW +: MW];
                op_b_q   <= bus.req_b[int'(pick_idx)*MW +: MW];
                owner_q  <= pick_idx;
                rr_ptr_q <= rr_next;
            end
            if (eng_out_fire) begin
                res_q <= bus.eng_res;
            end
            if (resp_fire) begin
                done_count_q <= done_count_q + 16'd1;
            end
        end
    end

    assign bus.eng_a      = op_a_q;
    assign bus.eng_b      = op_b_q;
    assign bus.resp_res   = res_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done_count = done_count_q;

endmodule
